// File: rtl/bcd_seven_seg_driver.sv
// ---------------------------------------------------------------------------
// BcdSevenSegDriver (top module bcd_seven_seg_driver)
//
// Converts a packed BCD value into active-low seven-segment patterns, one
// digit per clock from the most significant digit down to digit 0. The
// patterns are built in a temporary register and copied to the outputs in
// a single commit cycle, so the displays never show a half-converted value.
//
// Segment bit order per display is g..a (bit 0 = segment a), active low.
// Nibbles above 9 are shown as a dash and flag the committed value invalid.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits are blanked (digit 0 always shows its
//   value). When undefined, every digit shows its encoding and the blanking
//   flag does not exist.
// ---------------------------------------------------------------------------
module bcd_seven_seg_driver #(
    parameter int DIGITS    = 6,
    parameter int BCD_WIDTH = DIGITS * 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [BCD_WIDTH-1:0]  bcdValue,
    input  logic                  update,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid,
    output logic [DIGITS*7-1:0]   segments
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;

    logic                    w_start;
    logic                    w_convert;
    logic                    w_commit;
    logic                    w_lastDigit;

    logic [BCD_WIDTH-1:0]    r_shadow;
    logic [IDX_W-1:0]        r_digitIdx;
    logic [DIGITS*7-1:0]     r_tempSeg;
    logic                    r_errAcc;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_invalid;
    logic [DIGITS*7-1:0]     r_segments;

    logic [3:0]              w_nibble;
    logic                    w_isDash;
    logic [6:0]              w_pattern;

`ifdef LEADING_ZERO_BLANK_EN
    logic                    r_blankFlag;
`endif

    // Maps one BCD nibble to its active-low g..a pattern; non-decimal codes give a dash.
    function automatic logic [6:0] encodeDigit(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

    assign w_lastDigit = (r_digitIdx == '0);

    // State register; reset drops any conversion in flight straight back to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus one-hot strobes telling the datapath which phase it is in.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_convert   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (update) begin
                    w_start     = 1'b1;
                    w_nextState = CONVERT;
                end
            end
            CONVERT: begin
                w_convert = 1'b1;
                if (w_lastDigit) begin
                    w_nextState = COMMIT;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Selects the nibble of the captured value addressed by the current digit index.
    always_comb begin
        w_nibble = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_digitIdx == IDX_W'(k)) begin
                w_nibble = r_shadow[k*4 +: 4];
            end
        end
    end

    // Pattern for the digit being converted, including optional leading-zero blanking.
    always_comb begin
        w_isDash  = (w_nibble > 4'd9);
        w_pattern = encodeDigit(w_nibble);
`ifdef LEADING_ZERO_BLANK_EN
        if (!w_isDash && r_blankFlag && (w_nibble == 4'd0) && !w_lastDigit) begin
            w_pattern = SEG_BLANK;
        end
`endif
    end

    // Captures the input once per conversion so later input changes cannot leak in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (w_start) begin
            r_shadow <= bcdValue;
        end
    end

    // Digit index walks from the top digit down to zero, one step per convert cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_digitIdx <= '0;
        end else if (w_start) begin
            r_digitIdx <= IDX_W'(DIGITS - 1);
        end else if (w_convert && !w_lastDigit) begin
            r_digitIdx <= r_digitIdx - IDX_W'(1);
        end
    end

    // Builds the full display image off to the side while the outputs stay stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tempSeg <= {DIGITS{SEG_BLANK}};
        end else if (w_convert) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (r_digitIdx == IDX_W'(k)) begin
                    r_tempSeg[k*7 +: 7] <= w_pattern;
                end
            end
        end
    end

    // Remembers whether any nibble of the current value was outside 0..9.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_errAcc <= 1'b0;
        end else if (w_start) begin
            r_errAcc <= 1'b0;
        end else if (w_convert && w_isDash) begin
            r_errAcc <= 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blanking stays armed until the first non-zero (or dash) digit is seen from the top.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_blankFlag <= 1'b1;
        end else if (w_start) begin
            r_blankFlag <= 1'b1;
        end else if (w_convert && (w_nibble != 4'd0)) begin
            r_blankFlag <= 1'b0;
        end
    end
`endif

    // Busy covers the capture edge through the last convert edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_busy <= 1'b1;
        end else if (w_commit) begin
            r_busy <= 1'b0;
        end
    end

    // Publishes the finished image, the error flag and a one-cycle done pulse together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_segments <= {DIGITS{SEG_BLANK}};
            r_invalid  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_segments <= r_tempSeg;
                r_invalid  <= r_errAcc;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign invalid  = r_invalid;
    assign segments = r_segments;

endmodule

// File: tb/tb_bcd_seven_seg_driver.sv
// ---------------------------------------------------------------------------
// Testbench for bcd_seven_seg_driver. Expected displays come from a digit
// table and a "most significant non-zero digit" rule evaluated on the whole
// value; the LEADING_ZERO_BLANK_EN macro selects the blanking rule here too.
// ---------------------------------------------------------------------------
module tb_bcd_seven_seg_driver;

    localparam int DIGITS = 6;
    localparam int SEGW   = DIGITS * 7;
    localparam int BCDW   = DIGITS * 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] ENC [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [SEGW-1:0] ALL_BLANK = {DIGITS{7'h7F}};

    logic            clock;
    logic            reset;
    logic [BCDW-1:0] bcdValue;
    logic            update;
    logic            busy;
    logic            done;
    logic            invalid;
    logic [SEGW-1:0] segments;

    int checks;
    int fails;
    logic [SEGW-1:0] shownSegs;

    bcd_seven_seg_driver #(.DIGITS(DIGITS)) dut (
        .clock    (clock),
        .reset    (reset),
        .bcdValue (bcdValue),
        .update   (update),
        .busy     (busy),
        .done     (done),
        .invalid  (invalid),
        .segments (segments)
    );

    // Free-running clock, rising edge active.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Whole-value view of the display: blank every digit above the highest non-zero one.
    function automatic logic [SEGW-1:0] model_segments(input logic [BCDW-1:0] v);
        logic [SEGW-1:0] s;
        logic [3:0]      nib;
        int              msd;
        msd = 0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[d*4 +: 4] != 4'd0) msd = d;
        end
        s = '0;
        for (int d = 0; d < DIGITS; d++) begin
            nib = v[d*4 +: 4];
            if (nib > 4'd9)           s[d*7 +: 7] = 7'h3F;
            else if (LZB && d > msd)  s[d*7 +: 7] = 7'h7F;
            else                      s[d*7 +: 7] = ENC[nib];
        end
        return s;
    endfunction

    function automatic logic model_invalid(input logic [BCDW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[d*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Drive a one-cycle update; returns just after the sampling edge.
    task automatic applyStimulus(input logic [BCDW-1:0] v);
        @(negedge clock);
        bcdValue = v;
        update   = 1'b1;
        @(posedge clock);
        #1;
        update = 1'b0;
    endtask

    // Counts rising edges until done is seen; -1 when the budget runs out.
    task automatic wait_done(input int budget, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = -1;
        for (int i = 1; i <= budget && !found; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                found  = 1'b1;
                cycles = i;
            end
        end
    endtask

    task automatic test_reset();
        bit idleOk;
        reset    = 1'b1;
        update   = 1'b0;
        bcdValue = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (segments !== ALL_BLANK) begin fails++; $display("[TB] FAIL reset_segments got=%h want=%h", segments, ALL_BLANK); end
        checks++; if (busy !== 1'b0)    begin fails++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0)    begin fails++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        checks++; if (invalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_invalid got=%b want=0", invalid); end
        @(negedge clock);
        reset = 1'b0;
        idleOk = 1'b1;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (segments !== ALL_BLANK || busy !== 1'b0 || done !== 1'b0 || invalid !== 1'b0) idleOk = 1'b0;
        end
        checks++; if (!idleOk) begin fails++; $display("[TB] FAIL idle_after_reset got=not_idle want=idle"); end
        shownSegs = ALL_BLANK;
    endtask

    task automatic test_basic();
        logic [SEGW-1:0] want;
        want = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
        applyStimulus(24'h123456);
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy_edgeN got=%b want=1", busy); end
        for (int e = 1; e <= DIGITS + 1; e++) begin
            @(posedge clock);
            #1;
            checks++; if (busy !== (e <= DIGITS)) begin fails++; $display("[TB] FAIL basic_busy_edge%0d got=%b want=%b", e, busy, (e <= DIGITS)); end
            checks++; if (done !== (e == DIGITS + 1)) begin fails++; $display("[TB] FAIL basic_done_edge%0d got=%b want=%b", e, done, (e == DIGITS + 1)); end
            checks++; if (segments !== ((e <= DIGITS) ? shownSegs : want)) begin fails++; $display("[TB] FAIL basic_segments_edge%0d got=%h want=%h", e, segments, ((e <= DIGITS) ? shownSegs : want)); end
        end
        checks++; if (invalid !== 1'b0) begin fails++; $display("[TB] FAIL basic_invalid got=%b want=0", invalid); end
        @(posedge clock);
        #1;
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_width got=%b want=0", done); end
        shownSegs = want;
    endtask

    task automatic test_leading_zero();
        logic [SEGW-1:0] want;
        int cyc;
        if (LZB) want = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24};
        else     want = {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24};
        applyStimulus(24'h000042);
        wait_done(30, cyc);
        checks++; if (cyc != DIGITS + 1) begin fails++; $display("[TB] FAIL lz42_latency got=%0d want=%0d", cyc, DIGITS + 1); end
        checks++; if (segments !== want) begin fails++; $display("[TB] FAIL lz42_segments got=%h want=%h", segments, want); end
        if (LZB) want = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        else     want = {DIGITS{7'h40}};
        applyStimulus(24'h000000);
        wait_done(30, cyc);
        checks++; if (segments !== want) begin fails++; $display("[TB] FAIL lz0_segments got=%h want=%h", segments, want); end
        applyStimulus(24'h100000);
        wait_done(30, cyc);
        checks++; if (segments !== model_segments(24'h100000)) begin fails++; $display("[TB] FAIL lz_inner_zeros got=%h want=%h", segments, model_segments(24'h100000)); end
        shownSegs = segments;
    endtask

    task automatic test_invalid();
        int cyc;
        applyStimulus(24'h00A009);
        wait_done(30, cyc);
        checks++; if (segments[3*7 +: 7] !== 7'h3F) begin fails++; $display("[TB] FAIL inv_digit3 got=%h want=3f", segments[3*7 +: 7]); end
        checks++; if (segments[0 +: 7] !== 7'h10) begin fails++; $display("[TB] FAIL inv_digit0 got=%h want=10", segments[0 +: 7]); end
        checks++; if (segments !== model_segments(24'h00A009)) begin fails++; $display("[TB] FAIL inv_segments got=%h want=%h", segments, model_segments(24'h00A009)); end
        checks++; if (invalid !== 1'b1) begin fails++; $display("[TB] FAIL inv_flag_set got=%b want=1", invalid); end
        applyStimulus(24'h000001);
        wait_done(30, cyc);
        checks++; if (invalid !== 1'b0) begin fails++; $display("[TB] FAIL inv_flag_clear got=%b want=0", invalid); end
        shownSegs = segments;
    endtask

    task automatic test_random();
        logic [BCDW-1:0] v;
        int cyc;
        for (int n = 0; n < 24; n++) begin
            v = '0;
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 3) == 0) v[d*4 +: 4] = 4'd0;
                else if ($urandom_range(0, 5) == 0) v[d*4 +: 4] = 4'($urandom_range(10, 15));
                else v[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 2) == 0) v = v & ({BCDW{1'b1}} >> (4 * $urandom_range(1, DIGITS - 1)));
            applyStimulus(v);
            wait_done(30, cyc);
            checks++; if (cyc != DIGITS + 1) begin fails++; $display("[TB] FAIL rand_latency v=%h got=%0d want=%0d", v, cyc, DIGITS + 1); end
            checks++; if (segments !== model_segments(v)) begin fails++; $display("[TB] FAIL rand_segments v=%h got=%h want=%h", v, segments, model_segments(v)); end
            checks++; if (invalid !== model_invalid(v)) begin fails++; $display("[TB] FAIL rand_invalid v=%h got=%b want=%b", v, invalid, model_invalid(v)); end
            shownSegs = segments;
        end
    endtask

    task automatic test_ignore_busy();
        int doneCount;
        applyStimulus(24'h111111);
        repeat (2) @(posedge clock);
        @(negedge clock);
        update   = 1'b1;
        bcdValue = 24'($urandom);
        @(negedge clock);
        update   = 1'b0;
        bcdValue = 24'($urandom);
        doneCount = 0;
        repeat (2 * (DIGITS + 2) + 4) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) doneCount++;
        end
        checks++; if (doneCount != 1) begin fails++; $display("[TB] FAIL ignore_done_count got=%0d want=1", doneCount); end
        checks++; if (segments !== {DIGITS{7'h79}}) begin fails++; $display("[TB] FAIL ignore_segments got=%h want=%h", segments, {DIGITS{7'h79}}); end
        shownSegs = segments;
    endtask

    task automatic test_back_to_back();
        logic [BCDW-1:0] a;
        logic [BCDW-1:0] b;
        int cyc;
        int extra;
        a = 24'h987654;
        b = 24'h000305;
        @(negedge clock);
        bcdValue = a;
        update   = 1'b1;
        wait_done(30, cyc);
        checks++; if (cyc != DIGITS + 2) begin fails++; $display("[TB] FAIL b2b_first got=%0d want=%0d", cyc, DIGITS + 2); end
        checks++; if (segments !== model_segments(a)) begin fails++; $display("[TB] FAIL b2b_seg_a got=%h want=%h", segments, model_segments(a)); end
        bcdValue = b;
        wait_done(30, cyc);
        update = 1'b0;
        checks++; if (cyc != DIGITS + 2) begin fails++; $display("[TB] FAIL b2b_spacing got=%0d want=%0d", cyc, DIGITS + 2); end
        checks++; if (segments !== model_segments(b)) begin fails++; $display("[TB] FAIL b2b_seg_b got=%h want=%h", segments, model_segments(b)); end
        extra = 0;
        repeat (2 * (DIGITS + 2)) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin fails++; $display("[TB] FAIL b2b_no_extra got=%0d want=0", extra); end
        shownSegs = segments;
    endtask

    task automatic test_reset_abort();
        int cyc;
        int doneCount;
        applyStimulus(24'h999999);
        wait_done(30, cyc);
        checks++; if (segments !== {DIGITS{7'h10}}) begin fails++; $display("[TB] FAIL abort_prior got=%h want=%h", segments, {DIGITS{7'h10}}); end
        applyStimulus(24'h123456);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (segments !== ALL_BLANK) begin fails++; $display("[TB] FAIL abort_segments got=%h want=%h", segments, ALL_BLANK); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL abort_done got=%b want=0", done); end
        @(negedge clock);
        reset = 1'b0;
        doneCount = 0;
        repeat (2 * (DIGITS + 2)) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || segments !== ALL_BLANK) doneCount++;
        end
        checks++; if (doneCount != 0) begin fails++; $display("[TB] FAIL abort_no_commit got=%0d want=0", doneCount); end
        applyStimulus(24'h000001);
        wait_done(30, cyc);
        checks++; if (cyc != DIGITS + 1) begin fails++; $display("[TB] FAIL abort_fresh_latency got=%0d want=%0d", cyc, DIGITS + 1); end
        checks++; if (segments !== model_segments(24'h000001)) begin fails++; $display("[TB] FAIL abort_fresh_segments got=%h want=%h", segments, model_segments(24'h000001)); end
        shownSegs = segments;
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        checks    = 0;
        fails     = 0;
        reset     = 1'b1;
        update    = 1'b0;
        bcdValue  = '0;
        shownSegs = ALL_BLANK;
        $display("[TB] starting, leading-zero blanking = %0d", LZB);
        test_reset();
        test_basic();
        test_leading_zero();
        test_invalid();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bcd_seven_seg_driver.md
BCD_SEVEN_SEG_DRIVER -- requirements
Module: bcd_seven_seg_driver

Interface
REQ-001 The block SHALL have parameter DIGITS, default 6, number of BCD digits and seven-segment displays driven.
REQ-002 The block SHALL have parameter BCD_WIDTH, default DIGITS*4, width of the packed BCD input.
REQ-003 The block SHALL have port clock, input, 1 bit, clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, reset, asynchronous, active-high.
REQ-005 The block SHALL have port bcdValue, input, BCD_WIDTH bits, packed BCD; nibble 0 (bits 3:0) is the least significant digit.
REQ-006 The block SHALL have port update, input, 1 bit, request to convert bcdValue; sampled only in IDLE.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, single-cycle pulse when segments are updated.
REQ-009 The block SHALL have port invalid, output, 1 bit, high when the last committed value contained a nibble >9.
REQ-010 The block SHALL have port segments, output, DIGITS*7 bits, active-low patterns; display k occupies bits 7k+6:7k; bit order g..a (bit0=a).

Function
REQ-011 The FSM SHALL have states IDLE, CONVERT and COMMIT.
REQ-012 In IDLE with update=1, the block SHALL capture bcdValue into a shadow register, set digit index to DIGITS-1, set the blanking flag, clear the error accumulator, assert busy and enter CONVERT.
REQ-013 In IDLE with update=0, the block SHALL hold all outputs, with done=0.
REQ-014 CONVERT SHALL process exactly one digit per cycle from index DIGITS-1 down to 0, writing its pattern into a temporary segment register.
REQ-015 Digit encodings SHALL be 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, blank=0x7F.
REQ-016 A nibble >9 SHALL encode as dash 0x3F, set the error accumulator and clear the blanking flag.
REQ-017 After digit index 0 is processed, the block SHALL enter COMMIT.
REQ-018 COMMIT SHALL copy the temporary register to segments, copy the error accumulator to invalid, pulse done for one cycle, deassert busy and return to IDLE.
REQ-019 Latency: with update sampled at edge N, segments, invalid and done SHALL change at edge N+DIGITS+1; busy is high from edge N through edge N+DIGITS.
REQ-020 update asserted while busy=1 SHALL be ignored; it is not queued.
REQ-021 update held high continuously SHALL restart a conversion on the first IDLE cycle after COMMIT, i.e. one conversion per DIGITS+2 cycles.
REQ-022 Changes on bcdValue during CONVERT SHALL NOT affect the result; only the shadow register is used.
REQ-023 segments SHALL change only in COMMIT, so displays never show a partially converted value.

Reset
REQ-024 On reset, state SHALL be IDLE, busy=0, done=0, invalid=0, and every segments digit SHALL be 0x7F (blank).
REQ-025 Reset asserted mid-conversion SHALL abort the conversion immediately without committing; the first update after reset release starts a fresh conversion.

Configuration
REQ-026 With macro LEADING_ZERO_BLANK_EN defined, a zero nibble SHALL encode as blank (0x7F) while the blanking flag is set and index != 0; the first non-zero nibble clears the flag; digit 0 always shows its value.
REQ-027 Without LEADING_ZERO_BLANK_EN, every digit SHALL show its encoding and the blanking flag SHALL be absent.

Verification
REQ-028 Reset release, no update -> segments all 0x7F, busy=0, done=0, invalid=0 indefinitely.
REQ-029 Value 0x123456 with update pulsed at edge N -> done high for exactly one cycle at edge N+7; segments digit5..0 = 0x79, 0x24, 0x30, 0x19, 0x12, 0x02; invalid=0.
REQ-030 Value 0x000042 with LEADING_ZERO_BLANK_EN defined -> digits 5..2 = 0x7F, digit1 = 0x19, digit0 = 0x24. Without the macro -> digits 5..2 = 0x40. Value 0x000000 with the macro -> only digit0 = 0x40.
REQ-031 Value 0x00A009 -> digit3 = 0x3F, digit0 = 0x10, invalid=1. A subsequent update with 0x000001 -> invalid=0.
REQ-032 A second update pulse and a bcdValue change injected 3 cycles after accepting 0x111111 -> one done only; segments show 0x111111 (all 0x79).
REQ-033 Reset asserted 2 cycles after update with a prior display of 0x999999 -> immediately segments all 0x7F, busy=0, and no done pulse.
